// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: function codes, FSM state
// encoding and default widths.
package alu_pkg;

  localparam int ALU_N      = 8;
  localparam int ALU_CODE_W = 2;

  // Function codes; RB and RB_ALT are two encodings of the same pass-through.
  localparam logic [1:0] RB     = 2'd0;
  localparam logic [1:0] RB_ALT = 2'd1;
  localparam logic [1:0] RADD   = 2'd2;
  localparam logic [1:0] RMULT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/iter_alu_if.sv
// Request/response bundle of the iterative ALU.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer raising valid keeps its payload stable until the
// transfer; ready may be driven independently of valid.
interface iter_alu_if
  import alu_pkg::*;
#(
  parameter int N      = ALU_N,
  parameter int CODE_W = ALU_CODE_W
);

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] func;
  logic [N-1:0]      a;
  logic [N-1:0]      b;
  logic              out_valid;
  logic              out_ready;
  logic [N-1:0]      result;
  logic              ovf;

  modport master (
    output in_valid, func, a, b, out_ready,
    input  in_ready, out_valid, result, ovf
  );

  modport slave (
    input  in_valid, func, a, b, out_ready,
    output in_ready, out_valid, result, ovf
  );

endinterface

// File: rtl/iter_alu_mul.sv
// Sequential signed fractional multiplier for the iterative ALU.
// a is Q1.(N-1), b is an integer; q = floor(a*b / 2^(N-1)) at full
// precision (N+1 bits) so the caller can detect overflow.
// Magnitudes are multiplied by N shift-add steps over a 2N-bit accumulator;
// the sign is applied at the end. done is high during the cycle in which the
// last step is taken, and q then already reflects that step.
module iter_alu_mul
  import alu_pkg::*;
#(
  parameter int N = ALU_N
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N:0]   q
);

  localparam int CNT_W = $clog2(N + 1);

  logic [2*N-1:0] acc;
  logic [2*N-1:0] acc_step;
  logic [2*N-1:0] prod;
  logic [N-1:0]   mcand;
  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic [N:0]     add_sum;
  logic           neg;
  logic           busy;
  logic [CNT_W-1:0] cnt;

  // Operand magnitudes, one shift-add step, and the signed, scaled product
  always_comb begin
    a_mag    = a[N-1] ? -a : a;
    b_mag    = b[N-1] ? -b : b;
    add_sum  = acc[0] ? ({1'b0, acc[2*N-1:N]} + {1'b0, mcand})
                      : {1'b0, acc[2*N-1:N]};
    acc_step = {add_sum, acc[N-1:1]};
    prod     = neg ? -acc_step : acc_step;
    q        = (N+1)'($signed(prod) >>> (N - 1));
    done     = busy && (cnt == CNT_W'(N - 1));
  end

  // Load operands on start, then run exactly N iteration steps
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      acc   <= '0;
      mcand <= '0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      cnt   <= '0;
    end else if (start) begin
      acc   <= {{N{1'b0}}, b_mag};
      mcand <= a_mag;
      neg   <= a[N-1] ^ b[N-1];
      busy  <= 1'b1;
      cnt   <= '0;
    end else if (busy) begin
      acc <= acc_step;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU top: pass-through (RB/RB_ALT), add (RADD) and an N-cycle
// fractional multiply (RMULT), with a one-deep result held until taken.
// Optional build macro ALU_SAT_EN: clamp overflowing RADD/RMULT results to
// the signed N-bit range instead of wrapping; ovf is reported either way.
module iter_alu
  import alu_pkg::*;
#(
  parameter int N      = ALU_N,
  parameter int CODE_W = ALU_CODE_W
) (
  input  logic        clk,
  input  logic        nReset,
  iter_alu_if.slave   bus,
  output alu_state_e  dbg_state
);

  alu_state_e   state;
  alu_state_e   state_nx;
  logic         is_mult;
  logic         accept;
  logic         mul_start;
  logic         mul_done;
  logic         load;
  logic [N:0]   mul_q;
  logic [N:0]   alu_full;
  logic [N:0]   full_sel;
  logic         ovf_c;
  logic [N-1:0] res_c;
  logic [N-1:0] result_q;
  logic         ovf_q;

  assign is_mult = (bus.func == CODE_W'(RMULT));

  iter_alu_mul #(.N(N)) u_mul (
    .clk    (clk),
    .nReset (nReset),
    .start  (mul_start),
    .a      (bus.a),
    .b      (bus.b),
    .done   (mul_done),
    .q      (mul_q)
  );

  // State register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nx;
  end

  // Next-state: single-cycle ops skip MUL; DONE waits for the consumer
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_nx = is_mult ? MUL : DONE;
      MUL:     if (mul_done)     state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs and datapath strobes
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    accept        = (state == IDLE) && bus.in_valid;
    mul_start     = accept && is_mult;
    load          = (accept && !is_mult) || ((state == MUL) && mul_done);
    dbg_state     = state;
  end

  // Full-precision result selection, overflow detection and wrap/clamp
  always_comb begin
    if (bus.func == CODE_W'(RADD))
      alu_full = {bus.a[N-1], bus.a} + {bus.b[N-1], bus.b};
    else
      alu_full = {bus.b[N-1], bus.b};
    full_sel = (state == MUL) ? mul_q : alu_full;
    ovf_c    = full_sel[N] ^ full_sel[N-1];
`ifdef ALU_SAT_EN
    if (ovf_c)
      res_c = full_sel[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    else
      res_c = full_sel[N-1:0];
`else
    res_c = full_sel[N-1:0];
`endif
  end

  // Result register: written once per operation, held through DONE
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else if (load) begin
      result_q <= res_c;
      ovf_q    <= ovf_c;
    end
  end

  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_iter_alu.sv
// Directed testbench for iter_alu (N = 8). Expected values are hand-computed.
module tb_iter_alu;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       nReset;
  alu_state_e dbg_state;
  int         n_checks = 0;
  int         n_fail   = 0;

`ifdef ALU_SAT_EN
  localparam logic [7:0] EXP_ADD_POS_OVF = 8'h7F;
  localparam logic [7:0] EXP_ADD_NEG_OVF = 8'h80;
  localparam logic [7:0] EXP_MUL_OVF     = 8'h7F;
`else
  localparam logic [7:0] EXP_ADD_POS_OVF = 8'hC8;  // 200 wraps to -56
  localparam logic [7:0] EXP_ADD_NEG_OVF = 8'h38;  // -200 wraps to 56
  localparam logic [7:0] EXP_MUL_OVF     = 8'h80;  // 128 wraps to -128
`endif

  iter_alu_if #(.N(8), .CODE_W(2)) bus ();

  iter_alu #(.N(8), .CODE_W(2)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // driver: one request, wait for out_valid (bounded), take the result
  task automatic run_op(input logic [1:0] f, input logic [7:0] av, input logic [7:0] bv,
                        output logic [7:0] r, output logic o, output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.func = f; bus.a = av; bus.b = bv;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    r = bus.result;
    o = bus.ovf;
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 8'h00 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state in_ready=%b out_valid=%b result=%h ovf=%b required 1 0 00 0",
               bus.in_ready, bus.out_valid, bus.result, bus.ovf);
    end
    @(negedge clk); nReset = 1'b1;
  endtask

  task automatic test_rb();
    logic [7:0] r; logic o; int lat;
    run_op(RB, 8'd0, 8'd3, r, o, lat);
    n_checks++;
    if (r !== 8'd3 || o !== 1'b0 || lat !== 1) begin
      n_fail++;
      $display("FAIL rb_0_3 result=%h ovf=%b lat=%0d required 03 0 1", r, o, lat);
    end
    run_op(RB_ALT, 8'd77, 8'hFB, r, o, lat);
    n_checks++;
    if (r !== 8'hFB || o !== 1'b0 || lat !== 1) begin
      n_fail++;
      $display("FAIL rb_alt_m5 result=%h ovf=%b lat=%0d required fb 0 1", r, o, lat);
    end
  endtask

  task automatic test_radd();
    logic [7:0] va [5] = '{8'd3,  8'd8,  8'd100, 8'h9C, 8'h80};
    logic [7:0] vb [5] = '{8'd16, 8'hEC, 8'd100, 8'h9C, 8'h7F};
    logic [7:0] vr [5] = '{8'd19, 8'hF4, EXP_ADD_POS_OVF, EXP_ADD_NEG_OVF, 8'hFF};
    logic       vo [5] = '{1'b0,  1'b0,  1'b1,   1'b1,  1'b0};
    logic [7:0] r; logic o; int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(RADD, va[i], vb[i], r, o, lat);
      n_checks++;
      if (r !== vr[i] || o !== vo[i] || lat !== 1) begin
        n_fail++;
        $display("FAIL radd_%0d a=%h b=%h result=%h ovf=%b lat=%0d required %h %b 1",
                 i, va[i], vb[i], r, o, lat, vr[i], vo[i]);
      end
    end
  endtask

  task automatic test_rmult();
    // 0.75*8=6, 0.5*16=8, -0.5*8=-4, floor(-3/128)=-1, floor(127/128)=0, -1.0*100=-100
    logic [7:0] va [6] = '{8'h60, 8'h40, 8'hC0, 8'hFF, 8'h7F, 8'h80};
    logic [7:0] vb [6] = '{8'd8,  8'd16, 8'd8,  8'd3,  8'd1,  8'd100};
    logic [7:0] vr [6] = '{8'd6,  8'd8,  8'hFC, 8'hFF, 8'h00, 8'h9C};
    logic [7:0] r; logic o; int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(RMULT, va[i], vb[i], r, o, lat);
      n_checks++;
      if (r !== vr[i] || o !== 1'b0 || lat !== 9) begin
        n_fail++;
        $display("FAIL rmult_%0d a=%h b=%h result=%h ovf=%b lat=%0d required %h 0 9",
                 i, va[i], vb[i], r, o, lat, vr[i]);
      end
    end
  endtask

  task automatic test_rmult_ovf();
    logic [7:0] r; logic o; int lat;
    run_op(RMULT, 8'h80, 8'h80, r, o, lat);
    n_checks++;
    if (r !== EXP_MUL_OVF || o !== 1'b1 || lat !== 9) begin
      n_fail++;
      $display("FAIL rmult_ovf result=%h ovf=%b lat=%0d required %h 1 9", r, o, lat, EXP_MUL_OVF);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.func = RADD; bus.a = 8'd3; bus.b = 8'd16;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_out_valid out_valid=%b required 1", bus.out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.result !== 8'd19 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d result=%h in_ready=%b out_valid=%b required 13 0 1",
                 i, bus.result, bus.in_ready, bus.out_valid);
      end
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_ignore_busy();
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.func = RMULT; bus.a = 8'h40; bus.b = 8'd16;
    @(posedge clk); #1;
    // competing request while busy must have no effect
    bus.func = RB; bus.b = 8'd55;
    lat = 1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_in_ready in_ready=%b required 0", bus.in_ready);
    end
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.result !== 8'd8 || lat !== 9) begin
      n_fail++;
      $display("FAIL busy_ignore result=%h lat=%0d required 08 9", bus.result, lat);
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1; bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    int seen;
    logic [7:0] r; logic o; int lat;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.func = RMULT; bus.a = 8'h60; bus.b = 8'd8;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 nReset = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 8'h00 || dbg_state !== IDLE) begin
      n_fail++;
      $display("FAIL reset_mid_mul in_ready=%b out_valid=%b result=%h state=%0d required 1 0 00 0",
               bus.in_ready, bus.out_valid, bus.result, dbg_state);
    end
    @(negedge clk); nReset = 1'b1;
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0 || bus.result !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_no_stale out_valid_cycles=%0d result=%h required 0 00", seen, bus.result);
    end
    run_op(RB, 8'd0, 8'd3, r, o, lat);
    n_checks++;
    if (r !== 8'd3 || lat !== 1) begin
      n_fail++;
      $display("FAIL reset_recover result=%h lat=%0d required 03 1", r, lat);
    end
  endtask

  initial begin
    nReset        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.func      = RB;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_rb();
    test_radd();
    test_rmult();
    test_rmult_ovf();
    test_backpressure();
    test_ignore_busy();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
